// File: rtl/change_dispenser_pkg.sv
// Shared definitions for the change dispenser: coin codes (common with the
// coin-accept path), denomination values and FSM state encoding.
package change_dispenser_pkg;

  localparam logic [2:0] COIN_NONE = 3'b000;
  localparam logic [2:0] COIN_5    = 3'b001;
  localparam logic [2:0] COIN_10   = 3'b010;
  localparam logic [2:0] COIN_50   = 3'b011;
  localparam logic [2:0] COIN_100  = 3'b100;
  localparam logic [2:0] COIN_500  = 3'b101;

  localparam int unsigned NUM_DENOM = 5;

  typedef enum logic [1:0] {
    S_IDLE,
    S_SELECT,
    S_ISSUE,
    S_DONE
  } state_t;

  // Rupee value of a coin code; zero for non-coin codes.
  function automatic logic [15:0] denom_value(input logic [2:0] code);
    case (code)
      COIN_5:   return 16'd5;
      COIN_10:  return 16'd10;
      COIN_50:  return 16'd50;
      COIN_100: return 16'd100;
      COIN_500: return 16'd500;
      default:  return 16'd0;
    endcase
  endfunction

  function automatic logic is_coin(input logic [2:0] code);
    return (code >= COIN_5) && (code <= COIN_500);
  endfunction

  // Inventory slot for a coin code (slot 0 holds the 5-rupee count).
  function automatic logic [2:0] denom_idx(input logic [2:0] code);
    return code - 3'd1;
  endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request, hopper and inventory-load signals of the change dispenser.
// slave = dispenser side, master = controller / hopper side.
interface change_dispenser_if #(
  parameter int unsigned CNT_W = 8
) ();
  logic              req_valid;
  logic [15:0]       req_amount;
  logic              req_ready;
  logic [2:0]        coin_code;
  logic              coin_valid;
  logic              coin_ack;
  logic              done;
  logic [15:0]       shortfall;
  logic              busy;
  logic              load_en;
  logic [2:0]        load_code;
  logic [CNT_W-1:0]  load_count;
  logic              jam;

  modport master (
    output req_valid, req_amount, coin_ack, load_en, load_code, load_count,
    input  req_ready, coin_code, coin_valid, done, shortfall, busy, jam
  );

  modport slave (
    input  req_valid, req_amount, coin_ack, load_en, load_code, load_count,
    output req_ready, coin_code, coin_valid, done, shortfall, busy, jam
  );
endinterface

// File: rtl/change_denom_select.sv
// Combinational greedy picker: largest denomination that fits the remaining
// amount and still has stock.
module change_denom_select
  import change_dispenser_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic [15:0]      remaining,
  input  logic [CNT_W-1:0] counts [NUM_DENOM],
  output logic             found,
  output logic [2:0]       code,
  output logic [15:0]      value
);

  // Ascending scan: a later (larger) hit overrides a smaller one.
  always_comb begin
    found = 1'b0;
    code  = COIN_NONE;
    value = '0;
    for (int unsigned i = 0; i < NUM_DENOM; i++) begin
      if ((counts[i] != '0) && (denom_value(3'(i + 1)) <= remaining)) begin
        found = 1'b1;
        code  = 3'(i + 1);
        value = denom_value(3'(i + 1));
      end
    end
  end

endmodule

// File: rtl/change_dispenser.sv
// Change dispenser: breaks a rupee amount into coins (greedy, inventory
// limited) and issues them one at a time over a valid/ack handshake.
// Optional jam timeout: define CHANGE_DISPENSER_TIMEOUT_EN.
module change_dispenser
  import change_dispenser_pkg::*;
#(
  parameter int unsigned CNT_W      = 8,
  parameter int unsigned INIT_COUNT = 0,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic               clk,
  input  logic               reset,
  change_dispenser_if.slave  bus
);

  state_t            state;
  state_t            next_state;
  logic [15:0]       remaining;
  logic [15:0]       shortfall;
  logic [15:0]       issue_value;
  logic [2:0]        coin_code;
  logic [CNT_W-1:0]  counts [NUM_DENOM];
  logic              sel_found;
  logic [2:0]        sel_code;
  logic [15:0]       sel_value;
  logic              timeout_hit;
  logic              jam_q;

  change_denom_select #(.CNT_W(CNT_W)) u_select (
    .remaining (remaining),
    .counts    (counts),
    .found     (sel_found),
    .code      (sel_code),
    .value     (sel_value)
  );

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
  localparam int unsigned WAIT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic [WAIT_W-1:0] wait_cnt;

  // ISSUE lasts at most TIMEOUT cycles: wait_cnt runs 0..TIMEOUT-1.
  assign timeout_hit = (state == S_ISSUE) && !bus.coin_ack &&
                       (wait_cnt == WAIT_W'(TIMEOUT - 1));

  // Wait counter cleared in SELECT so it starts at zero on ISSUE entry; sticky jam.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt <= '0;
      jam_q    <= 1'b0;
    end else begin
      if (state == S_ISSUE) wait_cnt <= wait_cnt + WAIT_W'(1);
      else                  wait_cnt <= '0;
      if (timeout_hit) jam_q <= 1'b1;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign jam_q       = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next_state;
  end

  // Next-state logic.
  always_comb begin
    next_state = state;
    case (state)
      S_IDLE:   if (bus.req_valid) next_state = jam_q ? S_DONE : S_SELECT;
      S_SELECT: next_state = sel_found ? S_ISSUE : S_DONE;
      S_ISSUE: begin
        if (bus.coin_ack)      next_state = S_SELECT;
        else if (timeout_hit)  next_state = S_DONE;
      end
      S_DONE:   next_state = S_IDLE;
      default:  next_state = S_IDLE;
    endcase
  end

  // Outputs decoded from state; coin_valid falls with the async reset of state.
  always_comb begin
    bus.req_ready  = (state == S_IDLE);
    bus.busy       = (state != S_IDLE);
    bus.done       = (state == S_DONE);
    bus.coin_valid = (state == S_ISSUE);
    bus.coin_code  = coin_code;
    bus.shortfall  = shortfall;
    bus.jam        = jam_q;
  end

  // Datapath: remaining amount, shortfall, issued coin and inventory.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      remaining   <= '0;
      shortfall   <= '0;
      issue_value <= '0;
      coin_code   <= COIN_NONE;
      for (int unsigned i = 0; i < NUM_DENOM; i++) counts[i] <= CNT_W'(INIT_COUNT);
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            remaining <= bus.req_amount;
            shortfall <= jam_q ? bus.req_amount : '0;
          end
          if (bus.load_en && is_coin(bus.load_code))
            counts[denom_idx(bus.load_code)] <= bus.load_count;
        end
        S_SELECT: begin
          if (sel_found) begin
            coin_code   <= sel_code;
            issue_value <= sel_value;
          end else begin
            shortfall <= remaining;
          end
        end
        S_ISSUE: begin
          if (bus.coin_ack) begin
            remaining                    <= remaining - issue_value;
            counts[denom_idx(coin_code)] <= counts[denom_idx(coin_code)] - CNT_W'(1);
          end else if (timeout_hit) begin
            shortfall <= remaining;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_change_dispenser.sv
// Self-checking bench for change_dispenser: directed plan steps plus a
// randomized phase, all checked against a greedy reference model.
module tb_change_dispenser;

  localparam int CNT_W      = 8;
  localparam int INIT_COUNT = 2;
  localparam int TIMEOUT    = 16;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  int   inv [5];
  bit   m_jam;
  int   val_tab [5];

  change_dispenser_if #(.CNT_W(CNT_W)) bus ();

  change_dispenser #(
    .CNT_W      (CNT_W),
    .INIT_COUNT (INIT_COUNT),
    .TIMEOUT    (TIMEOUT)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic check_counts(input string tag);
    for (int i = 0; i < 5; i++)
      check($sformatf("%s_count%0d", tag, val_tab[i]), 32'(dut.counts[i]), inv[i]);
  endtask

  task automatic load_inv(input logic [2:0] code, input int cnt);
    bus.load_en    = 1'b1;
    bus.load_code  = code;
    bus.load_count = CNT_W'(cnt);
    if (code >= 3'd1 && code <= 3'd5) inv[code - 3'd1] = cnt;
    @(negedge clk);
    bus.load_en = 1'b0;
  endtask

  task automatic run_request(input int amount, input int ack_delay, input bit load_busy,
                             input bit co_load, input logic [2:0] co_code, input int co_cnt,
                             input int exp_done_cyc, input string tag);
    int exp_q [$];
    int tmp [5];
    int rem;
    int n;
    int cyc;
    int idx;
    bit fin;
    logic [2:0] code_seen;
    check({tag, "_ready"}, 32'(bus.req_ready), 1);
    if (co_load && co_code >= 3'd1 && co_code <= 3'd5) inv[co_code - 3'd1] = co_cnt;
    tmp = inv;
    rem = amount;
    if (!m_jam)
      for (int d = 4; d >= 0; d--)
        while (rem >= val_tab[d] && tmp[d] > 0) begin
          exp_q.push_back(d);
          rem -= val_tab[d];
          tmp[d]--;
        end
    bus.req_valid  = 1'b1;
    bus.req_amount = 16'(amount);
    if (co_load) begin
      bus.load_en    = 1'b1;
      bus.load_code  = co_code;
      bus.load_count = CNT_W'(co_cnt);
    end
    n = 0; cyc = 0; fin = 1'b0;
    while (!fin && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      bus.req_valid = 1'b0;
      bus.load_en   = 1'b0;
      if (bus.done === 1'b1) fin = 1'b1;
      else if (bus.coin_valid === 1'b1) begin
        code_seen = bus.coin_code;
        idx = (n < exp_q.size()) ? exp_q[n] : -1;
        check($sformatf("%s_coin%0d_code", tag, n), 32'(code_seen), 32'(idx + 1));
        for (int k = 0; k < ack_delay; k++) begin
          if (load_busy && k == 0) begin
            bus.load_en    = 1'b1;
            bus.load_code  = code_seen;
            bus.load_count = CNT_W'(99);
          end
          @(negedge clk);
          cyc++;
          bus.load_en = 1'b0;
          check({tag, "_hold_valid"}, 32'(bus.coin_valid), 1);
          check({tag, "_hold_code"}, 32'(bus.coin_code), 32'(code_seen));
          if (idx >= 0) check({tag, "_hold_count"}, 32'(dut.counts[idx]), inv[idx]);
        end
        bus.coin_ack = 1'b1;
        @(negedge clk);
        cyc++;
        bus.coin_ack = 1'b0;
        if (idx >= 0) inv[idx]--;
        n++;
      end
    end
    check({tag, "_done_seen"}, 32'(fin), 1);
    if (exp_done_cyc > 0) check({tag, "_latency"}, cyc, exp_done_cyc);
    check({tag, "_coins"}, n, exp_q.size());
    check({tag, "_shortfall"}, 32'(bus.shortfall), rem);
    @(negedge clk);
    check({tag, "_done_pulse"}, 32'(bus.done), 0);
    check({tag, "_idle"}, 32'(bus.req_ready), 1);
    check_counts(tag);
  endtask

  initial begin
    int vcyc;
    bit fin;
    checks = 0;
    errors = 0;
    m_jam  = 1'b0;
    val_tab = '{5, 10, 50, 100, 500};
    for (int i = 0; i < 5; i++) inv[i] = INIT_COUNT;
    reset          = 1'b0;
    bus.req_valid  = 1'b0;
    bus.req_amount = '0;
    bus.coin_ack   = 1'b0;
    bus.load_en    = 1'b0;
    bus.load_code  = '0;
    bus.load_count = '0;
    repeat (3) @(negedge clk);
    check("rst_req_ready", 32'(bus.req_ready), 1);
    check("rst_coin_valid", 32'(bus.coin_valid), 0);
    check("rst_coin_code", 32'(bus.coin_code), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_shortfall", 32'(bus.shortfall), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_jam", 32'(bus.jam), 0);
    reset = 1'b1;
    @(negedge clk);
    check_counts("rst");

    // Plan 1: 265 from 500x0,100x2,50x1,10x3,5x1 -> 100,100,50,10,5
    load_inv(3'd5, 0); load_inv(3'd4, 2); load_inv(3'd3, 1);
    load_inv(3'd2, 3); load_inv(3'd1, 1);
    run_request(265, 0, 1'b0, 1'b0, 3'd0, 0, 0, "t1");

    // Plan 2: 5x4, request 7 -> one 5, shortfall 2
    load_inv(3'd1, 4);
    run_request(7, 1, 1'b0, 1'b0, 3'd0, 0, 0, "t2");

    // Plan 3: 100x0, 50x3, request 100 -> 50,50
    load_inv(3'd4, 0); load_inv(3'd3, 3);
    run_request(100, 0, 1'b0, 1'b0, 3'd0, 0, 0, "t3");

    // Plan 4: zero amount, done two cycles after accept
    run_request(0, 0, 1'b0, 1'b0, 3'd0, 0, 2, "t4");

    // Plan 5: long ack stall with a load attempted while busy
    load_inv(3'd2, 5);
    run_request(10, 10, 1'b1, 1'b0, 3'd0, 0, 0, "t5");

    // Reserved coin codes are not inventory slots
    load_inv(3'd6, 9); load_inv(3'd7, 9); load_inv(3'd0, 9);
    check_counts("badcode");

    // Load in the accept cycle is seen by the first selection
    run_request(500, 0, 1'b0, 1'b1, 3'd5, 1, 0, "ldacc");

    // Residues and exhausted stock
    run_request(1003, 2, 1'b0, 1'b0, 3'd0, 0, 0, "resid");

    // Randomized requests against the model
    for (int r = 0; r < 25; r++) begin
      int nl;
      nl = $urandom_range(0, 3);
      for (int k = 0; k < nl; k++)
        load_inv(3'($urandom_range(0, 7)), $urandom_range(0, 4));
      run_request($urandom_range(0, 1300), $urandom_range(0, 3), 1'b0,
                  1'($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)),
                  $urandom_range(0, 3), 0, $sformatf("rnd%0d", r));
    end
    check("nojam", 32'(bus.jam), 0);

`ifdef CHANGE_DISPENSER_TIMEOUT_EN
    // Plan 6: hopper never acks -> jam after TIMEOUT cycles
    load_inv(3'd4, 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = 16'd100;
    vcyc = 0; fin = 1'b0;
    for (int c = 0; c < 100 && !fin; c++) begin
      @(negedge clk);
      bus.req_valid = 1'b0;
      if (bus.done === 1'b1) fin = 1'b1;
      else if (bus.coin_valid === 1'b1) begin
        if (vcyc == 0) check("to_code", 32'(bus.coin_code), 4);
        vcyc++;
      end
    end
    check("to_done_seen", 32'(fin), 1);
    check("to_valid_cycles", vcyc, TIMEOUT);
    check("to_valid_low", 32'(bus.coin_valid), 0);
    check("to_jam", 32'(bus.jam), 1);
    check("to_shortfall", 32'(bus.shortfall), 100);
    @(negedge clk);
    check_counts("to");
    m_jam = 1'b1;
    run_request(35, 0, 1'b0, 1'b0, 3'd0, 0, 1, "jamreq");
    check("jam_sticky", 32'(bus.jam), 1);
`else
    vcyc = 0;
    fin  = 1'b0;
`endif

    // Reset mid-request aborts the coin and restores inventory
    load_inv(3'd5, 1);
    bus.req_valid  = 1'b1;
    bus.req_amount = 16'd500;
    @(negedge clk);
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("mid_valid_before", 32'(bus.coin_valid), 1);
    #2 reset = 1'b0;
    #1;
    check("mid_valid_async", 32'(bus.coin_valid), 0);
    check("mid_busy", 32'(bus.busy), 0);
    check("mid_jam", 32'(bus.jam), 0);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) inv[i] = INIT_COUNT;
    m_jam = 1'b0;
    @(negedge clk);
    check_counts("mid");
    check("mid_shortfall", 32'(bus.shortfall), 0);
    run_request(60, 1, 1'b0, 1'b0, 3'd0, 0, 0, "post");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
